fetch_stage: RTL and testbench

Instruction-fetch (IF) stage and IF/ID pipeline register of the 5-stage MIPS pipeline. It sits directly upstream of the hazard detection unit: it produces instructionD and consumes the unit's PCWrite/IF_IDWrite stall controls. Owns the PC, a single-outstanding request/ack handshake to instruction memory, a one-entry hold buffer for responses that arrive during a stall, and branch/jump redirect with flush.

---
 rtl/fetch_stage.sv | 213 +++++++++++++++++++++
 tb/tb_fetch_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage plus IF/ID pipeline register.
// Owns the PC, runs one outstanding request/ack fetch to instruction memory,
// buffers a response that lands during a stall, and applies branch/jump
// redirects with an IF/ID flush.
//
// Optional build macro: FETCH_PERF_CNT_EN enables the stall/bubble counters.
// Without it, stall_cnt/bubble_cnt are tied to zero.
//
// Ports:
//   CLOCK, RESET_N          clock, async active-low reset
//   PCWrite, IF_IDWrite     hazard-unit stall controls (0 = hold)
//   redirect_valid/_pc      taken branch/jump target from downstream
//   imem_req/addr           fetch request to instruction memory
//   imem_ack/rdata          single-cycle response from instruction memory
//   instructionD/pcD/validD IF/ID register contents
//   stall_cnt, bubble_cnt   performance counters (zero unless enabled)
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned PC_STEP   = 4,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        CLOCK,
   input  logic        RESET_N,
   input  logic        PCWrite,
   input  logic        IF_IDWrite,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instructionD,
   output logic [31:0] pcD,
   output logic        validD,
   output logic [31:0] stall_cnt,
   output logic [31:0] bubble_cnt
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2,
      S_DRAIN = 2'd3
   } state_e;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic            valid;
   } ifid_t;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } hold_t;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] redir_q, redir_d;
   ifid_t           ifid_q, ifid_d;
   hold_t           hold_q, hold_d;
   logic            req_q, req_d;

   logic            stall;
   logic            bub_wr;
   logic [XLEN-1:0] pc_inc;
   logic [XLEN-1:0] redir_tgt;
   ifid_t           bubble;

   // Mismatched PCWrite/IF_IDWrite are treated as a stall.
   assign stall     = ~PCWrite | ~IF_IDWrite;
   assign pc_inc    = pc_q + XLEN'(PC_STEP);
   assign redir_tgt = redirect_pc & ~32'h0000_0003;
   assign bubble    = '{instr: NOP_INSTR, pc: ifid_q.pc, valid: 1'b0};

   // Next-state and IF/ID update.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      redir_d = redir_q;
      ifid_d  = ifid_q;
      hold_d  = hold_q;
      bub_wr  = 1'b0;

      if (redirect_valid) begin
         // Redirect wins over stall; flush IF/ID and drop any held response.
         ifid_d = bubble;
         bub_wr = 1'b1;
         case (state_q)
            S_FETCH, S_DRAIN: begin
               if (imem_ack) begin
                  pc_d    = redir_tgt;
                  state_d = S_FETCH;
               end else begin
                  // Request still in flight: let it complete before retargeting.
                  redir_d = redir_tgt;
                  state_d = S_DRAIN;
               end
            end
            default: begin
               pc_d    = redir_tgt;
               state_d = S_FETCH;
            end
         endcase
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_FETCH;
            end
            S_FETCH: begin
               if (imem_ack && !stall) begin
                  ifid_d = '{instr: imem_rdata, pc: pc_q, valid: 1'b1};
                  pc_d   = pc_inc;
               end else if (imem_ack) begin
                  hold_d  = '{instr: imem_rdata, pc: pc_q};
                  state_d = S_HOLD;
               end else if (!stall) begin
                  ifid_d = bubble;
                  bub_wr = 1'b1;
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  ifid_d  = '{instr: hold_q.instr, pc: hold_q.pc, valid: 1'b1};
                  pc_d    = pc_inc;
                  state_d = S_FETCH;
               end
            end
            S_DRAIN: begin
               // The stale response is discarded; IF/ID keeps showing bubbles.
               if (imem_ack) begin
                  pc_d    = redir_q;
                  state_d = S_FETCH;
               end
               if (!stall) begin
                  ifid_d = bubble;
                  bub_wr = 1'b1;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      req_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
   end

   // State and pipeline registers.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         redir_q <= '0;
         ifid_q  <= '{instr: NOP_INSTR, pc: '0, valid: 1'b0};
         hold_q  <= '0;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         redir_q <= redir_d;
         ifid_q  <= ifid_d;
         hold_q  <= hold_d;
         req_q   <= req_d;
      end
   end

   // The PC only moves once the request is acked, so it doubles as the
   // outstanding request address in both S_FETCH and S_DRAIN.
   assign imem_req     = req_q;
   assign imem_addr    = pc_q;
   assign instructionD = ifid_q.instr;
   assign pcD          = ifid_q.pc;
   assign validD       = ifid_q.valid;

`ifdef FETCH_PERF_CNT_EN
   logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;
   logic [XLEN-1:0] bubble_cnt_q, bubble_cnt_d;

   // Saturating performance counters.
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (stall && (state_q != S_IDLE) && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + XLEN'(1);
      end
      if (bub_wr && (bubble_cnt_q != '1)) begin
         bubble_cnt_d = bubble_cnt_q + XLEN'(1);
      end
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`else
   logic unused_bub_wr;
   assign unused_bub_wr = bub_wr;
   assign stall_cnt     = '0;
   assign bubble_cnt    = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a per-cycle table of stall/redirect inputs
// and memory latency with hand-computed IF/ID and request expectations, then
// a hand-written reset-during-hold sequence. Memory returns addr+0x100.
module tb_fetch_stage;

   logic        CLOCK;
   logic        RESET_N;
   logic        PCWrite;
   logic        IF_IDWrite;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instructionD;
   logic [31:0] pcD;
   logic        validD;
   logic [31:0] stall_cnt;
   logic [31:0] bubble_cnt;

   int checks = 0;
   int errors = 0;
   int wait_cnt = 0;

   typedef struct {
      logic        pcw;
      logic        ifw;
      logic        rv;
      logic [31:0] rpc;
      int          lat;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pcd;
      logic [31:0] e_instr;
   } vec_t;

   localparam int NV = 31;
   vec_t tbl [NV];

   fetch_stage dut (
      .CLOCK          (CLOCK),
      .RESET_N        (RESET_N),
      .PCWrite        (PCWrite),
      .IF_IDWrite     (IF_IDWrite),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .instructionD   (instructionD),
      .pcD            (pcD),
      .validD         (validD),
      .stall_cnt      (stall_cnt),
      .bubble_cnt     (bubble_cnt)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   function automatic vec_t mk(input logic pcw, input logic ifw, input logic rv,
                               input logic [31:0] rpc, input int lat,
                               input logic e_req, input logic [31:0] e_addr,
                               input logic e_valid, input logic [31:0] e_pcd,
                               input logic [31:0] e_instr);
      vec_t v;
      v.pcw = pcw; v.ifw = ifw; v.rv = rv; v.rpc = rpc; v.lat = lat;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
      v.e_pcd = e_pcd; v.e_instr = e_instr;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h required %h", name, act, exp);
      end
   endtask

   // Starts and ends on a falling edge; memory answers after lat request cycles.
   task automatic step(input string tag, input vec_t v);
      logic req_seen;
      logic ack_given;
      PCWrite        = v.pcw;
      IF_IDWrite     = v.ifw;
      redirect_valid = v.rv;
      redirect_pc    = v.rpc;
      req_seen       = imem_req;
      ack_given      = imem_req && (wait_cnt >= v.lat - 1);
      imem_ack       = ack_given;
      imem_rdata     = ack_given ? imem_addr + 32'h100 : 32'hDEAD_BEEF;
      @(posedge CLOCK);
      #1;
      chk({tag, ".req"},   32'(imem_req),     32'(v.e_req));
      chk({tag, ".addr"},  imem_addr,         v.e_addr);
      chk({tag, ".valid"}, 32'(validD),       32'(v.e_valid));
      chk({tag, ".pcD"},   pcD,               v.e_pcd);
      chk({tag, ".instr"}, instructionD,      v.e_instr);
      if (ack_given)     wait_cnt = 0;
      else if (req_seen) wait_cnt++;
      else               wait_cnt = 0;
      @(negedge CLOCK);
   endtask

   initial begin
      //                pcw  ifw  rv   rpc           lat  req  addr          v    pcD           instr
      tbl[0]  = mk(1, 1, 0, 32'h0,        1,  1, 32'h0,        0, 32'h0,        32'h0);
      tbl[1]  = mk(1, 1, 0, 32'h0,        1,  1, 32'h4,        1, 32'h0,        32'h100);
      tbl[2]  = mk(1, 1, 0, 32'h0,        1,  1, 32'h8,        1, 32'h4,        32'h104);
      tbl[3]  = mk(0, 0, 0, 32'h0,        1,  0, 32'h8,        1, 32'h4,        32'h104);
      tbl[4]  = mk(0, 0, 0, 32'h0,        1,  0, 32'h8,        1, 32'h4,        32'h104);
      tbl[5]  = mk(0, 0, 0, 32'h0,        1,  0, 32'h8,        1, 32'h4,        32'h104);
      tbl[6]  = mk(1, 1, 0, 32'h0,        1,  1, 32'hC,        1, 32'h8,        32'h108);
      tbl[7]  = mk(1, 1, 1, 32'h40,       1,  1, 32'h40,       0, 32'h8,        32'h0);
      tbl[8]  = mk(1, 1, 0, 32'h0,        1,  1, 32'h44,       1, 32'h40,       32'h140);
      tbl[9]  = mk(1, 1, 0, 32'h0,        1,  1, 32'h48,       1, 32'h44,       32'h144);
      tbl[10] = mk(1, 1, 0, 32'h0,        3,  1, 32'h48,       0, 32'h44,       32'h0);
      tbl[11] = mk(1, 1, 0, 32'h0,        3,  1, 32'h48,       0, 32'h44,       32'h0);
      tbl[12] = mk(1, 1, 0, 32'h0,        3,  1, 32'h4C,       1, 32'h48,       32'h148);
      tbl[13] = mk(1, 1, 0, 32'h0,        3,  1, 32'h4C,       0, 32'h48,       32'h0);
      tbl[14] = mk(1, 1, 0, 32'h0,        3,  1, 32'h4C,       0, 32'h48,       32'h0);
      tbl[15] = mk(1, 1, 0, 32'h0,        3,  1, 32'h50,       1, 32'h4C,       32'h14C);
      tbl[16] = mk(1, 1, 1, 32'h83,       3,  1, 32'h50,       0, 32'h4C,       32'h0);
      tbl[17] = mk(1, 1, 0, 32'h0,        3,  1, 32'h50,       0, 32'h4C,       32'h0);
      tbl[18] = mk(1, 1, 0, 32'h0,        3,  1, 32'h80,       0, 32'h4C,       32'h0);
      tbl[19] = mk(1, 1, 0, 32'h0,        1,  1, 32'h84,       1, 32'h80,       32'h180);
      tbl[20] = mk(1, 0, 0, 32'h0,        1,  0, 32'h84,       1, 32'h80,       32'h180);
      tbl[21] = mk(0, 1, 1, 32'h20,       1,  1, 32'h20,       0, 32'h80,       32'h0);
      tbl[22] = mk(1, 1, 0, 32'h0,        1,  1, 32'h24,       1, 32'h20,       32'h120);
      tbl[23] = mk(0, 1, 0, 32'h0,        3,  1, 32'h24,       1, 32'h20,       32'h120);
      tbl[24] = mk(1, 1, 0, 32'h0,        3,  1, 32'h24,       0, 32'h20,       32'h0);
      tbl[25] = mk(1, 1, 0, 32'h0,        3,  1, 32'h28,       1, 32'h24,       32'h124);
      tbl[26] = mk(1, 1, 1, 32'h200,      3,  1, 32'h28,       0, 32'h24,       32'h0);
      tbl[27] = mk(1, 1, 1, 32'hFFFFFFFE, 3,  1, 32'h28,       0, 32'h24,       32'h0);
      tbl[28] = mk(1, 1, 0, 32'h0,        3,  1, 32'hFFFFFFFC, 0, 32'h24,       32'h0);
      tbl[29] = mk(1, 1, 0, 32'h0,        1,  1, 32'h0,        1, 32'hFFFFFFFC, 32'hFC);
      tbl[30] = mk(1, 1, 0, 32'h0,        1,  1, 32'h4,        1, 32'h0,        32'h100);

      RESET_N        = 1'b0;
      PCWrite        = 1'b1;
      IF_IDWrite     = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_ack       = 1'b0;
      imem_rdata     = '0;

      repeat (2) @(posedge CLOCK);
      @(negedge CLOCK);
      chk("rst.req",    32'(imem_req),  32'h0);
      chk("rst.addr",   imem_addr,      32'h0);
      chk("rst.valid",  32'(validD),    32'h0);
      chk("rst.pcD",    pcD,            32'h0);
      chk("rst.instr",  instructionD,   32'h0);
      chk("rst.stall",  stall_cnt,      32'h0);
      chk("rst.bubble", bubble_cnt,     32'h0);
      RESET_N = 1'b1;

      for (int i = 0; i < NV; i++) begin
         step($sformatf("row%0d", i), tbl[i]);
      end

      // Stall with the ack for addr 4 so the response parks in the hold buffer.
      step("hold", mk(0, 0, 0, 32'h0, 1, 0, 32'h4, 1, 32'h0, 32'h100));

      // Asynchronous reset in the middle of the hold.
      #2;
      RESET_N = 1'b0;
      #1;
      chk("mrst.req",    32'(imem_req), 32'h0);
      chk("mrst.addr",   imem_addr,     32'h0);
      chk("mrst.valid",  32'(validD),   32'h0);
      chk("mrst.pcD",    pcD,           32'h0);
      chk("mrst.instr",  instructionD,  32'h0);
      chk("mrst.stall",  stall_cnt,     32'h0);
      chk("mrst.bubble", bubble_cnt,    32'h0);
      @(negedge CLOCK);
      RESET_N  = 1'b1;
      wait_cnt = 0;

      // Restart at RESET_PC against a 3-cycle memory.
      step("rs0", mk(1, 1, 0, 32'h0, 3, 1, 32'h0, 0, 32'h0, 32'h0));
      step("rs1", mk(1, 1, 0, 32'h0, 3, 1, 32'h0, 0, 32'h0, 32'h0));
      step("rs2", mk(1, 1, 0, 32'h0, 3, 1, 32'h0, 0, 32'h0, 32'h0));
      step("rs3", mk(1, 1, 0, 32'h0, 3, 1, 32'h4, 1, 32'h0, 32'h100));
`ifdef FETCH_PERF_CNT_EN
      chk("cnt.bubble", bubble_cnt, 32'd2);
      chk("cnt.stall0", stall_cnt,  32'd0);
`else
      chk("cnt.bubble", bubble_cnt, 32'd0);
      chk("cnt.stall0", stall_cnt,  32'd0);
`endif
      step("rs4", mk(0, 1, 0, 32'h0, 3, 1, 32'h4, 1, 32'h0, 32'h100));
`ifdef FETCH_PERF_CNT_EN
      chk("cnt.stall1", stall_cnt,  32'd1);
`else
      chk("cnt.stall1", stall_cnt,  32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
